// File: rtl/sr_input_conditioner_pkg.sv
// Shared constants for the SR latch input conditioner: debounce FSM encoding,
// default stability window and synchroniser depth.
package sr_cond_pkg;

  typedef enum logic [1:0] {
    ST_LOW      = 2'd0,
    ST_RISE_CHK = 2'd1,
    ST_HIGH     = 2'd2,
    ST_FALL_CHK = 2'd3
  } state_t;

  localparam int unsigned CNT_MAX_DEFAULT = 50000;
  localparam int unsigned SYNC_STAGES     = 2;

endpackage

// File: rtl/sr_input_conditioner_debounce_ch.sv
// One button channel: 2-flop synchroniser, stability counter, debounce FSM,
// registered debounced level and a single-cycle rising-edge strobe.
module debounce_ch
  import sr_cond_pkg::*;
#(
  parameter int unsigned CNT_MAX = CNT_MAX_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_db,
  output logic o_rise_c
);

  localparam int unsigned CW = $clog2(CNT_MAX + 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0]          r_cnt;
  state_t                 r_state;
  state_t                 w_state_nxt;
  logic                   r_db;
  logic                   r_db_d;
  logic                   w_db_nxt;
  logic                   w_sync;
  logic                   w_differ;
  logic                   w_expire;

  always_ff @(posedge clk) begin
    if (rst) r_sync <= '0;
    else     r_sync <= {r_sync[SYNC_STAGES-2:0], i_btn};
  end

  assign w_sync   = r_sync[SYNC_STAGES-1];
  assign w_differ = (w_sync != r_db);
  assign w_expire = w_differ && (r_cnt == CW'(CNT_MAX - 1));

  // Window restarts whenever the input agrees with the debounced level again
  always_ff @(posedge clk) begin
    if (rst)                        r_cnt <= '0;
    else if (!w_differ || w_expire) r_cnt <= '0;
    else                            r_cnt <= r_cnt + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_LOW;
      r_db    <= 1'b0;
      r_db_d  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_db    <= w_db_nxt;
      r_db_d  <= r_db;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_LOW:      if (w_sync) w_state_nxt = ST_RISE_CHK;
      ST_RISE_CHK: if (!w_sync) w_state_nxt = ST_LOW;
                   else if (w_expire) w_state_nxt = ST_HIGH;
      ST_HIGH:     if (!w_sync) w_state_nxt = ST_FALL_CHK;
      ST_FALL_CHK: if (w_sync) w_state_nxt = ST_HIGH;
                   else if (w_expire) w_state_nxt = ST_LOW;
    endcase
  end

  always_comb begin
    w_db_nxt = 1'b0;
    if (w_state_nxt == ST_HIGH || w_state_nxt == ST_FALL_CHK) w_db_nxt = 1'b1;
  end

  assign o_db     = r_db;
  assign o_rise_c = r_db & ~r_db_d;

endmodule

// File: rtl/sr_input_conditioner.sv
// Drives the SR latch s/r inputs from two raw buttons; s and r never overlap.
// Optional power-on clear pulse on r: define SR_INPUT_CONDITIONER_PWRON_CLR_EN.
module sr_input_conditioner
  import sr_cond_pkg::*;
#(
  parameter int unsigned CNT_MAX = CNT_MAX_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_s,
  input  logic btn_r,
  output logic s,
  output logic r,
  output logic s_db,
  output logic r_db,
  output logic conflict
);

  logic w_rise_s;
  logic w_rise_r;
  logic w_pwr_clr;

  debounce_ch #(.CNT_MAX(CNT_MAX)) u_db_s (
    .clk      (clk),
    .rst      (rst),
    .i_btn    (btn_s),
    .o_db     (s_db),
    .o_rise_c (w_rise_s)
  );

  debounce_ch #(.CNT_MAX(CNT_MAX)) u_db_r (
    .clk      (clk),
    .rst      (rst),
    .i_btn    (btn_r),
    .o_db     (r_db),
    .o_rise_c (w_rise_r)
  );

`ifdef SR_INPUT_CONDITIONER_PWRON_CLR_EN
  logic r_pwr_pend;

  // Armed throughout reset, consumed on the first cycle out of it
  always_ff @(posedge clk) begin
    if (rst) r_pwr_pend <= 1'b1;
    else     r_pwr_pend <= 1'b0;
  end

  assign w_pwr_clr = r_pwr_pend;
`else
  assign w_pwr_clr = 1'b0;
`endif

  // Simultaneous requests cancel each other and raise conflict instead
  always_ff @(posedge clk) begin
    if (rst) begin
      s        <= 1'b0;
      r        <= 1'b0;
      conflict <= 1'b0;
    end else begin
      s        <= w_rise_s & ~w_rise_r;
      r        <= (w_rise_r & ~w_rise_s) | w_pwr_clr;
      conflict <= w_rise_s & w_rise_r;
    end
  end

endmodule

// File: tb/tb_sr_input_conditioner.sv
// Directed scoreboard bench for sr_input_conditioner with CNT_MAX=4.
// Honours SR_INPUT_CONDITIONER_PWRON_CLR_EN for the post-reset r pulse.
module tb_sr_input_conditioner;

  localparam int unsigned CNT_MAX = 4;
`ifdef SR_INPUT_CONDITIONER_PWRON_CLR_EN
  localparam bit PWR = 1'b1;
`else
  localparam bit PWR = 1'b0;
`endif

  typedef struct {
    logic s;
    logic r;
    logic c;
    logic sdb;
    logic rdb;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic btn_s;
  logic btn_r;
  logic s;
  logic r;
  logic s_db;
  logic r_db;
  logic conflict;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;

  sr_input_conditioner #(.CNT_MAX(CNT_MAX)) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_s    (btn_s),
    .btn_r    (btn_r),
    .s        (s),
    .r        (r),
    .s_db     (s_db),
    .r_db     (r_db),
    .conflict (conflict)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
    end
  endtask

  task automatic push(input logic es, input logic er, input logic ec,
                      input logic esdb, input logic erdb);
    exp_t e;
    e.s = es; e.r = er; e.c = ec; e.sdb = esdb; e.rdb = erdb;
    q.push_back(e);
  endtask

  // Advance n cycles, popping and checking one expectation per cycle
  task automatic run(input string tag, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (q.size() == 0) begin
        n_vec++;
        n_err++;
        $error("FAIL %s_underflow cyc=%0d observed=empty expected=entry", tag, cyc);
      end else begin
        e = q.pop_front();
        chk({tag, "_s"},        s,        e.s);
        chk({tag, "_r"},        r,        e.r);
        chk({tag, "_conflict"}, conflict, e.c);
        chk({tag, "_s_db"},     s_db,     e.sdb);
        chk({tag, "_r_db"},     r_db,     e.rdb);
      end
      chk({tag, "_excl"}, s & r, 1'b0);
    end
  endtask

  initial begin
    rst = 1'b1; btn_s = 1'b0; btn_r = 1'b0;

    // Reset state, then release with buttons low
    for (int k = 1; k <= 3; k++) push(0, 0, 0, 0, 0);
    run("reset", 3);
    for (int k = 1; k <= 3; k++) push(0, PWR && k == 1, 0, 0, 0);
    rst = 1'b0;
    run("pwron", 3);

    // Clean press of s, then release (no falling pulse)
    for (int k = 1; k <= 12; k++) push(k == 7, 0, 0, k >= 6, 0);
    btn_s = 1'b1;
    run("clean", 12);
    for (int k = 1; k <= 8; k++) push(0, 0, 0, k < 6, 0);
    btn_s = 1'b0;
    run("clean_rel", 8);

    // Bounce 1,0,1 at cycles 0,2,3 restarts the window
    for (int k = 1; k <= 13; k++) push(k == 10, 0, 0, k >= 9, 0);
    btn_s = 1'b1;
    run("bounce", 2);
    btn_s = 1'b0;
    run("bounce", 1);
    btn_s = 1'b1;
    run("bounce", 10);
    for (int k = 1; k <= 8; k++) push(0, 0, 0, k < 6, 0);
    btn_s = 1'b0;
    run("bounce_rel", 8);

    // Simultaneous press suppresses both pulses
    for (int k = 1; k <= 10; k++) push(0, 0, k == 7, k >= 6, k >= 6);
    btn_s = 1'b1; btn_r = 1'b1;
    run("simul", 10);
    for (int k = 1; k <= 8; k++) push(0, 0, 0, k < 6, k < 6);
    btn_s = 1'b0; btn_r = 1'b0;
    run("simul_rel", 8);

    // Reset asserted mid-debounce with s held
    for (int k = 1; k <= 15; k++)
      push(k == 12, PWR && k == 6, 0, k >= 11, 0);
    btn_s = 1'b1;
    run("rstmid", 3);
    rst = 1'b1;
    run("rstmid", 2);
    rst = 1'b0;
    run("rstmid", 10);
    for (int k = 1; k <= 8; k++) push(0, 0, 0, k < 6, 0);
    btn_s = 1'b0;
    run("rstmid_rel", 8);

    // Hold r for 20 cycles, then release
    for (int k = 1; k <= 30; k++) push(0, k == 7, 0, 0, k >= 6 && k < 26);
    btn_r = 1'b1;
    run("hold", 20);
    btn_r = 1'b0;
    run("hold", 10);

    // Hold s, press r three cycles later: both pulses pass independently
    for (int k = 1; k <= 12; k++) push(k == 7, k == 10, 0, k >= 6, k >= 9);
    btn_s = 1'b1;
    run("overlap", 3);
    btn_r = 1'b1;
    run("overlap", 9);
    for (int k = 1; k <= 8; k++) push(0, 0, 0, k < 6, k < 6);
    btn_s = 1'b0; btn_r = 1'b0;
    run("overlap_rel", 8);

    n_vec++;
    assert (q.size() == 0) else begin
      n_err++;
      $error("FAIL queue_drain observed=%0d expected=0", q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sr_input_conditioner.md
Name: sr_input_conditioner

Overview:
Front-end stage that drives the set/reset inputs of the asynchronous SR latch from two raw board push-buttons. Each button is synchronised, debounced, and edge-detected into a single-cycle pulse. The block guarantees that s and r are never high in the same cycle, so the latch never sees its forbidden input combination. It sits between the MAX1000 button pins and the latch's s/r inputs.

Parameters:
CNT_MAX, 50000, debounce stability window in clock cycles (about 4 ms at 12 MHz); legal range 2 and above.
CW, $clog2(CNT_MAX+1), counter width; derived, never overridden.

Ports:
clk  input  1  system clock
rst  input  1  reset; synchronous, active-high
btn_s  input  1  raw set button, active-high, asynchronous to clk
btn_r  input  1  raw reset button, active-high, asynchronous to clk
s  output  1  one-cycle set pulse to latch
r  output  1  one-cycle reset pulse to latch
s_db  output  1  debounced level of btn_s
r_db  output  1  debounced level of btn_r
conflict  output  1  one-cycle flag: simultaneous set/reset request suppressed

Behaviour:
- Reset: synchronisers, counters, s_db, r_db, s, r and conflict all go to 0. Reset mid-debounce discards the count. A button still held when rst deasserts is treated as a fresh press and debounced from zero.
- Synchroniser: each button passes through 2 flops. The raw edge at cycle N is visible as sync_x at cycle N+2.
- Debounce, per channel, identical and independent:
  - If sync_x equals x_db, the counter clears to 0.
  - Otherwise the counter increments each cycle.
  - On the cycle sync_x differs and the counter equals CNT_MAX-1, x_db toggles and the counter clears.
  - x_db therefore changes exactly CNT_MAX cycles after the first differing sync sample, provided the input stays stable.
  - Any bounce back to x_db before that restarts the window from 0.
- Per-channel state machine: LOW (x_db=0), RISE_CHK (counting toward 1), HIGH (x_db=1), FALL_CHK (counting toward 0).
  - LOW→RISE_CHK on sync=1.
  - RISE_CHK→LOW on sync=0.
  - RISE_CHK→HIGH on expiry.
  - The falling path is symmetric.
- Pulse generation (registered): rise_x = x_db high now and low in the previous cycle. s/r is asserted for exactly one cycle, the cycle after rise_x. Falling edges produce no pulse.
- Mutual exclusion:
  - If rise_s and rise_r occur in the same cycle, neither s nor r is asserted, and conflict=1 for that one cycle.
  - Otherwise each pulse passes through independently. Holding one button while pressing the other is legal, because the pulses cannot overlap.
- Invariant: s & r == 0 on every cycle.

Optional Feature:
Macro SR_INPUT_CONDITIONER_PWRON_CLR_EN.
- Defined: on the first cycle after rst deasserts, r pulses high for exactly one cycle, forcing the downstream latch to q=0. This cannot collide with s, because s needs at least CNT_MAX+3 cycles after reset. conflict is not affected.
- Undefined: no pulse after reset; the latch powers up in an undefined state until the first button press.

Decomposition:
- Shared package sr_cond_pkg holds:
  - the 2-bit state encoding constants ST_LOW=0, ST_RISE_CHK=1, ST_HIGH=2, ST_FALL_CHK=3;
  - the default CNT_MAX value;
  - the synchroniser depth constant SYNC_STAGES=2.
- One sub-module is natural: debounce_ch (synchroniser, counter, FSM, x_db, rise_x), instantiated twice.
- The top level adds the pulse register, the mutual-exclusion logic and the optional power-on clear.

Test Plan:
(All with CNT_MAX=4, clk cycles counted from the raw edge at cycle 0.)
1. Clean press: btn_s 0→1 held at cycle 0 → s_db=1 at cycle 6, s=1 only at cycle 7; r=0 and conflict=0 throughout.
2. Bounce: btn_s toggles 1,0,1 at cycles 0,2,3, then held → window restarts; s_db rises at cycle 9, single s pulse at cycle 10, no earlier pulse.
3. Simultaneous press: btn_s and btn_r rise together at cycle 0 → s=0 and r=0 at cycle 7, conflict=1 at cycle 7 only; s_db=r_db=1.
4. Reset mid-debounce: press at cycle 0, rst=1 at cycles 3-4 with button held → no pulse before reset; after reset s_db rises 6 cycles after rst falls, with one s pulse the following cycle.
5. Hold and release: btn_r held high for 20 cycles, then released → exactly one r pulse; r_db returns to 0 CNT_MAX+2 cycles after release; no pulse on release.
6. With SR_INPUT_CONDITIONER_PWRON_CLR_EN defined: deassert rst with buttons low → r=1 on the first post-reset cycle only. With the macro undefined, r stays 0.
